// File: rtl/tpu_sequencer.sv
// TPU job sequencer: weight reload, UB row streaming and result write-back for one matrix job.
// Optional macro TPU_SEQ_PERF_CNT_EN adds the perf_cycles job-length counter output.
`timescale 1ns/1ps

module tpu_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int RES_LAT     = 17
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] len,
  input  logic [ADDRESSSIZE-1:0] ub_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic [1:0]             w_sel,
  input  logic                   w_ready,
  output logic [1:0]             w_addr,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_rd_en,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   res_we,
  output logic                   busy,
  output logic                   done,
`ifdef TPU_SEQ_PERF_CNT_EN
  output logic [31:0]            perf_cycles,
`endif
  output logic                   err
);

  localparam int CW = 16;
  // Wide enough to hold RES_LAT + len without overflow for any legal setting.
  localparam int EW = ((ADDRESSSIZE > CW) ? ADDRESSSIZE : CW) + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_W = 3'd1,
    S_WLOAD  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cyc;
  logic [CW-1:0]          w_cyc_nxt;
  logic                   r_ph;
  logic                   w_ph_nxt;
  logic                   w_accept;

  logic [ADDRESSSIZE-1:0] r_len;
  logic [ADDRESSSIZE-1:0] r_ub_base;
  logic [ADDRESSSIZE-1:0] r_res_base;
  logic [1:0]             r_w_addr;
  logic                   r_we_rl;
  logic [ADDRESSSIZE-1:0] r_ub_addr;
  logic                   r_ub_rd_en;
  logic [ADDRESSSIZE-1:0] r_res_addr;
  logic                   r_res_we;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic [EW-1:0]          w_len_ext;
  logic [EW-1:0]          w_lat_ext;
  logic [EW-1:0]          w_last_ext;
  logic [EW-1:0]          w_cyc_ext;
  logic [EW-1:0]          w_cyc_nxt_ext;
  logic                   w_ub_en_nxt;
  logic                   w_res_en_nxt;
  logic [ADDRESSSIZE-1:0] w_ub_addr_nxt;
  logic [ADDRESSSIZE-1:0] w_res_addr_nxt;

  assign w_len_ext     = EW'(r_len);
  assign w_lat_ext     = EW'(RES_LAT);
  assign w_last_ext    = w_lat_ext + w_len_ext - EW'(1'b1);
  assign w_cyc_ext     = EW'(r_cyc);
  assign w_cyc_nxt_ext = EW'(w_cyc_nxt);

  // Next-state, stream cycle counter and WLOAD phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_ph_nxt    = r_ph;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WAIT_W;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_W: begin
        if (w_ready) begin
          w_state_nxt = S_WLOAD;
          w_ph_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_WAIT_W;
        end
      end
      S_WLOAD: begin
        // Phase 0 covers the weight SRAM read latency; reload fires in phase 1.
        if (!r_ph) begin
          w_ph_nxt = 1'b1;
        end else if (r_len == {ADDRESSSIZE{1'b0}}) begin
          w_state_nxt = S_DONE;
          w_ph_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_STREAM;
          w_ph_nxt    = 1'b0;
          w_cyc_nxt   = {CW{1'b0}};
        end
      end
      S_STREAM: begin
        if (w_cyc_ext == w_last_ext) begin
          w_state_nxt = S_DONE;
          w_cyc_nxt   = {CW{1'b0}};
        end else begin
          w_cyc_nxt = r_cyc + 16'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = {CW{1'b0}};
        w_ph_nxt    = 1'b0;
      end
    endcase
  end

  // Strobe and address values for the cycle being entered.
  always_comb begin
    w_ub_en_nxt    = 1'b0;
    w_res_en_nxt   = 1'b0;
    w_ub_addr_nxt  = r_ub_base + ADDRESSSIZE'(w_cyc_nxt_ext);
    w_res_addr_nxt = r_res_base + ADDRESSSIZE'(w_cyc_nxt_ext - w_lat_ext);
    if (w_state_nxt == S_STREAM) begin
      w_ub_en_nxt  = (w_cyc_nxt_ext < w_len_ext);
      w_res_en_nxt = (w_cyc_nxt_ext >= w_lat_ext) && (w_cyc_nxt_ext < (w_lat_ext + w_len_ext));
    end else begin
      w_ub_en_nxt  = 1'b0;
      w_res_en_nxt = 1'b0;
    end
  end

  // State, job latches and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cyc      <= {CW{1'b0}};
      r_ph       <= 1'b0;
      r_len      <= {ADDRESSSIZE{1'b0}};
      r_ub_base  <= {ADDRESSSIZE{1'b0}};
      r_res_base <= {ADDRESSSIZE{1'b0}};
      r_w_addr   <= 2'd0;
      r_we_rl    <= 1'b0;
      r_ub_addr  <= {ADDRESSSIZE{1'b0}};
      r_ub_rd_en <= 1'b0;
      r_res_addr <= {ADDRESSSIZE{1'b0}};
      r_res_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc      <= w_cyc_nxt;
      r_ph       <= w_ph_nxt;
      if (w_accept) begin
        r_len      <= len;
        r_ub_base  <= ub_base;
        r_res_base <= res_base;
        r_w_addr   <= w_sel;
      end
      r_we_rl    <= (w_state_nxt == S_WLOAD) && w_ph_nxt;
      r_ub_rd_en <= w_ub_en_nxt;
      r_res_we   <= w_res_en_nxt;
      if (w_ub_en_nxt) begin
        r_ub_addr <= w_ub_addr_nxt;
      end
      if (w_res_en_nxt) begin
        r_res_addr <= w_res_addr_nxt;
      end
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= r_err | (start && (r_state != S_IDLE));
    end
  end

  assign w_addr   = r_w_addr;
  assign we_rl    = r_we_rl;
  assign ub_addr  = r_ub_addr;
  assign ub_rd_en = r_ub_rd_en;
  assign res_addr = r_res_addr;
  assign res_we   = r_res_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0] r_pcnt;
  logic [31:0] r_perf;
  logic [31:0] w_pcnt_nxt;

  // Running job length: 1 in the first WAIT_W cycle, saturating at all-ones.
  always_comb begin
    w_pcnt_nxt = r_pcnt;
    if (w_accept) begin
      w_pcnt_nxt = 32'd1;
    end else if ((r_state != S_IDLE) && (r_pcnt != 32'hFFFF_FFFF)) begin
      w_pcnt_nxt = r_pcnt + 32'd1;
    end else begin
      w_pcnt_nxt = r_pcnt;
    end
  end

  // Counter and published value, captured as DONE is entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pcnt <= 32'd0;
      r_perf <= 32'd0;
    end else begin
      r_pcnt <= w_pcnt_nxt;
      if (w_state_nxt == S_DONE) begin
        r_perf <= w_pcnt_nxt;
      end
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule
